// File: rtl/m1t_gpo_monitor.sv
// Consumer of the M1T general-purpose output bus: decodes CHAR/PASS/FAIL commands,
// buffers characters in a FIFO and latches an end-of-test status with a watchdog.
module m1t_gpo_monitor #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        async_rst,
  input  logic        clk_en,
  input  logic [15:0] gpo,
  input  logic        char_ready,
  output logic        char_valid,
  output logic [7:0]  char_data,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [11:0] fail_code,
  output logic        overflow,
  output logic [15:0] event_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [3:0] CMD_CHAR = 4'h1;
  localparam logic [3:0] CMD_PASS = 4'h2;
  localparam logic [3:0] CMD_FAIL = 4'h3;

  typedef enum logic {ST_RUN, ST_DONE} state_e;

  state_e        state_q, state_d;
  logic [15:0]   gpo_q;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   idle_cnt_q, idle_cnt_d;
  logic          pass_q, pass_d;
  logic          timeout_q, timeout_d;
  logic [11:0]   fail_code_q, fail_code_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   event_count_q, event_count_d;
  logic [7:0]    mem_q [DEPTH];

  logic        evt;
  logic        pop;
  logic        push_req;
  logic        push_ok;
  logic [31:0] idle_inc;

  assign evt      = clk_en && (gpo != gpo_q) && (state_q == ST_RUN);
  assign pop      = (count_q != '0) && char_ready;
  assign idle_inc = idle_cnt_q + 32'd1;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    pass_d        = pass_q;
    timeout_d     = timeout_q;
    fail_code_d   = fail_code_q;
    overflow_d    = overflow_q;
    event_count_d = event_count_q;
    idle_cnt_d    = idle_cnt_q;
    push_req      = 1'b0;

    if (evt) begin
      // An event always wins over a watchdog expiry in the same cycle.
      idle_cnt_d = '0;
      if (event_count_q != 16'hFFFF) event_count_d = event_count_q + 16'd1;
      case (gpo[15:12])
        CMD_CHAR: push_req = 1'b1;
        CMD_PASS: begin
          state_d = ST_DONE;
          pass_d  = 1'b1;
        end
        CMD_FAIL: begin
          state_d     = ST_DONE;
          pass_d      = 1'b0;
          fail_code_d = gpo[11:0];
        end
        default: ;
      endcase
    end else if (clk_en && (state_q == ST_RUN)) begin
      idle_cnt_d = idle_inc;
      if ((TIMEOUT != 0) && (idle_inc == 32'(TIMEOUT))) begin
        state_d   = ST_DONE;
        timeout_d = 1'b1;
      end
    end

    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    push_ok = push_req && ((count_q < CW'(DEPTH)) || pop);
    if (push_req && !push_ok) overflow_d = 1'b1;

    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop     ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop)      count_d = count_q + CW'(1);
    else if (!push_ok && pop) count_d = count_q - CW'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state_q       <= ST_RUN;
      gpo_q         <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      idle_cnt_q    <= '0;
      pass_q        <= 1'b0;
      timeout_q     <= 1'b0;
      fail_code_q   <= '0;
      overflow_q    <= 1'b0;
      event_count_q <= '0;
    end else begin
      state_q       <= state_d;
      if (clk_en) gpo_q <= gpo;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      idle_cnt_q    <= idle_cnt_d;
      pass_q        <= pass_d;
      timeout_q     <= timeout_d;
      fail_code_q   <= fail_code_d;
      overflow_q    <= overflow_d;
      event_count_q <= event_count_d;
    end
  end

  // NOTE: the storage array has no reset; the count qualifies which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= gpo[7:0];
  end

  assign char_valid  = (count_q != '0);
  assign char_data   = mem_q[rd_ptr_q];
  assign done        = (state_q == ST_DONE);
  assign pass        = pass_q;
  assign timeout     = timeout_q;
  assign fail_code   = fail_code_q;
  assign overflow    = overflow_q;
  assign event_count = event_count_q;

endmodule

// File: tb/tb_m1t_gpo_monitor.sv
// Self-checking bench for m1t_gpo_monitor: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based behavioural model.
module tb_m1t_gpo_monitor;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        async_rst = 1'b1;
  logic        clk_en = 1'b0;
  logic [15:0] gpo = '0;
  logic        char_ready = 1'b0;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        done, pass, timeout, overflow;
  logic [11:0] fail_code;
  logic [15:0] event_count;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  logic [7:0]  m_q[$];
  logic [15:0] m_prev;
  bit          m_done, m_pass, m_timeout, m_ovf;
  logic [11:0] m_fail;
  int          m_events, m_idle;

  m1t_gpo_monitor #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .async_rst(async_rst), .clk_en(clk_en), .gpo(gpo),
    .char_ready(char_ready), .char_valid(char_valid), .char_data(char_data),
    .done(done), .pass(pass), .timeout(timeout), .fail_code(fail_code),
    .overflow(overflow), .event_count(event_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_prev = '0; m_done = 0; m_pass = 0; m_timeout = 0; m_ovf = 0;
    m_fail = '0; m_events = 0; m_idle = 0;
  endtask

  // Next model state from the current inputs, applied as the coming clock edge would.
  task automatic model_step();
    bit pop, ev;
    int size0;
    size0 = m_q.size();
    pop = (size0 > 0) && char_ready;
    ev  = clk_en && (gpo != m_prev) && !m_done;
    if (pop) void'(m_q.pop_front());
    if (ev) begin
      m_idle = 0;
      if (m_events < 65535) m_events++;
      case (gpo[15:12])
        4'h1: if (size0 < DEPTH || pop) m_q.push_back(gpo[7:0]); else m_ovf = 1;
        4'h2: begin m_done = 1; m_pass = 1; end
        4'h3: begin m_done = 1; m_pass = 0; m_fail = gpo[11:0]; end
        default: ;
      endcase
    end else if (clk_en && !m_done) begin
      m_idle++;
      if (TIMEOUT != 0 && m_idle == TIMEOUT) begin m_done = 1; m_timeout = 1; end
    end
    if (clk_en) m_prev = gpo;
  endtask

  task automatic compare_all();
    check("char_valid", char_valid, m_q.size() > 0);
    if (m_q.size() > 0) check("char_data", char_data, m_q[0]);
    check("done", done, m_done);
    check("pass", pass, m_pass);
    check("timeout", timeout, m_timeout);
    check("fail_code", fail_code, m_fail);
    check("overflow", overflow, m_ovf);
    check("event_count", event_count, m_events);
  endtask

  // Called #1 after a rising edge; inputs are already set for this cycle.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // Asserts reset mid-cycle, checks outputs clear before any edge, releases after one edge.
  task automatic do_reset();
    async_rst = 1'b1;
    #1;
    check("rst_char_valid", char_valid, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_fail_code", fail_code, 12'h0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_event_count", event_count, 16'h0);
    model_reset();
    @(posedge clk);
    #1;
    async_rst = 1'b0;
  endtask

  task automatic watchdog_run(input bit with_event);
    gpo = '0; clk_en = 1'b1; char_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      clk_en = (k % 2 == 0);
      if (with_event && k == 14) gpo = 16'h5000;
      cycle();
      if (k == 12) check("wd_before_8th", timeout, 1'b0);
    end
  endtask

  initial begin
    model_reset();
    #2;

    // Two characters streamed straight through
    clk_en = 1'b1; char_ready = 1'b1; gpo = '0;
    do_reset();
    gpo = 16'h1041; cycle();
    check("t1_data0", char_data, 8'h41);
    gpo = 16'h1042; cycle();
    check("t1_data1", char_data, 8'h42);
    cycle();
    check("t1_empty", char_valid, 1'b0);
    check("t1_events", event_count, 16'd2);

    // Fill, push+pop while full, overflow, then drain in order
    char_ready = 1'b0; gpo = '0;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      gpo = 16'h1000 | 16'(8'h30 + i); cycle();
    end
    check("t2_full_no_ovf", overflow, 1'b0);
    char_ready = 1'b1; gpo = 16'h1040; cycle();
    check("t2_pushpop_ovf", overflow, 1'b0);
    check("t2_pushpop_head", char_data, 8'h31);
    char_ready = 1'b0; gpo = 16'h1041; cycle();
    check("t2_ovf", overflow, 1'b1);
    char_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("t2_drain", char_data, 8'h31 + i);
      cycle();
    end
    check("t2_drained", char_valid, 1'b0);

    // Fail command, later pass command ignored
    char_ready = 1'b0; gpo = '0;
    do_reset();
    gpo = 16'h3ABC; cycle();
    check("t4_done", done, 1'b1);
    check("t4_fail_code", fail_code, 12'hABC);
    gpo = 16'h2000; cycle();
    check("t4_pass_ignored", pass, 1'b0);
    check("t4_events", event_count, 16'd1);

    // Watchdog fires on 8th enabled idle cycle; an event on that cycle prevents it
    watchdog_run(1'b0);
    check("wd_timeout", timeout, 1'b1);
    check("wd_done", done, 1'b1);
    watchdog_run(1'b1);
    check("wd_evt_timeout", timeout, 1'b0);
    check("wd_evt_done", done, 1'b0);
    check("wd_evt_events", event_count, 16'd1);

    // Reset while done with three bytes buffered
    clk_en = 1'b1; char_ready = 1'b0; gpo = '0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      gpo = 16'h1061 + 16'(i); cycle();
    end
    gpo = 16'h2000; cycle();
    check("t6_done", done, 1'b1);
    check("t6_pass", pass, 1'b1);
    do_reset();

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      int r;
      clk_en     = ($urandom_range(0, 3) != 0);
      char_ready = ($urandom_range(0, 2) != 0);
      r = $urandom_range(0, 99);
      if (r < 40)      ;
      else if (r < 80) gpo = {4'h1, 4'($urandom), 8'($urandom)};
      else if (r < 92) gpo = {4'($urandom_range(4, 15)), 12'($urandom)};
      else if (r < 96) gpo = {4'h2, 12'($urandom)};
      else             gpo = {4'h3, 12'($urandom)};
      if ((m_done && $urandom_range(0, 15) == 0) || $urandom_range(0, 299) == 0) do_reset();
      else cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
